// File: rtl/branch_pkg.sv
// Shared definitions for the branch resolve unit: condition codes and the
// 2-bit predictor counter encoding with its saturating step.
package branch_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [1:0] {
        CNT_STRONG_NT = 2'b00,
        CNT_WEAK_NT   = 2'b01,
        CNT_WEAK_T    = 2'b10,
        CNT_STRONG_T  = 2'b11
    } bht_state_e;

    localparam bht_state_e BHT_RESET = CNT_WEAK_NT;

    // Saturating step toward taken or not-taken.
    function automatic bht_state_e bht_next(bht_state_e cur, logic taken);
        bht_state_e nxt;
        nxt = cur;
        unique case (cur)
            CNT_STRONG_NT: nxt = taken ? CNT_WEAK_NT  : CNT_STRONG_NT;
            CNT_WEAK_NT:   nxt = taken ? CNT_WEAK_T   : CNT_STRONG_NT;
            CNT_WEAK_T:    nxt = taken ? CNT_STRONG_T : CNT_WEAK_NT;
            CNT_STRONG_T:  nxt = taken ? CNT_STRONG_T : CNT_WEAK_T;
            default:       nxt = BHT_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_history_table.sv
// Table of 2-bit saturating predictor counters with one combinational read
// port and one update port; reads return the value before a same-edge update.
module branch_history_table
    import branch_pkg::*;
#(
    parameter int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_state_e       rd_state,
    input  logic             upd_en,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    bht_state_e counters_q [DEPTH];

    assign rd_state = counters_q[rd_idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                counters_q[i] <= BHT_RESET;
            end
        end else if (upd_en) begin
            counters_q[upd_idx] <= bht_next(counters_q[upd_idx], upd_taken);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves conditional branches behind a one-deep valid/ready output register,
// trains the history table and keeps branch/misprediction statistics.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN      = 64,
    parameter int BHT_DEPTH = 16,
    parameter int CNT_W     = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [XLEN-1:0]  lookup_pc,
    output logic             lookup_taken,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             branch,
    input  logic [2:0]       funct3,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    input  logic [XLEN-1:0]  pc,
    input  logic             pred_taken,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sel,
    output logic             mispredict,
    output logic             illegal,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);

    localparam int IDX_W = $clog2(BHT_DEPTH);

    logic       accept;
    logic       cond_true;
    logic       legal;
    logic       sel_d;
    logic       illegal_d;
    logic       mispredict_d;
    logic       update;
    bht_state_e lookup_state;
    logic       unused_pc_bits;

    assign unused_pc_bits = ^{pc[XLEN-1:IDX_W+2], pc[1:0],
                              lookup_pc[XLEN-1:IDX_W+2], lookup_pc[1:0]};

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        cond_true = 1'b0;
        legal     = 1'b1;
        unique case (funct3)
            F3_BEQ:  cond_true = (a == b);
            F3_BNE:  cond_true = (a != b);
            F3_BLT:  cond_true = ($signed(a) <  $signed(b));
            F3_BGE:  cond_true = ($signed(a) >= $signed(b));
            F3_BLTU: cond_true = (a <  b);
            F3_BGEU: cond_true = (a >= b);
            default: legal     = 1'b0;
        endcase
    end

    assign sel_d        = branch && legal && cond_true;
    assign illegal_d    = branch && !legal;
    assign mispredict_d = sel_d ^ pred_taken;
    assign update       = accept && branch && legal;

    branch_history_table #(
        .DEPTH (BHT_DEPTH)
    ) u_bht (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (lookup_pc[IDX_W+1:2]),
        .rd_state  (lookup_state),
        .upd_en    (update),
        .upd_idx   (pc[IDX_W+1:2]),
        .upd_taken (sel_d)
    );

    assign lookup_taken = lookup_state[1];

    // Results load only on acceptance, so they hold while the consumer stalls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid  <= 1'b0;
            sel        <= 1'b0;
            mispredict <= 1'b0;
            illegal    <= 1'b0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            sel        <= sel_d;
            mispredict <= mispredict_d;
            illegal    <= illegal_d;
        end else if (out_ready) begin
            out_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else if (update) begin
            branch_count <= branch_count + 1'b1;
            if (mispredict_d) begin
                mispredict_count <= mispredict_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed and randomized checks of branch_resolve_unit against a
// table-and-counter reference model.
module tb_branch_resolve_unit;

    localparam int XLEN  = 64;
    localparam int DEPTH = 16;
    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [XLEN-1:0]  lookup_pc;
    logic             lookup_taken;
    logic             in_valid;
    logic             in_ready;
    logic             branch;
    logic [2:0]       funct3;
    logic [XLEN-1:0]  a;
    logic [XLEN-1:0]  b;
    logic [XLEN-1:0]  pc;
    logic             pred_taken;
    logic             out_valid;
    logic             out_ready;
    logic             sel;
    logic             mispredict;
    logic             illegal;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .XLEN      (XLEN),
        .BHT_DEPTH (DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .lookup_pc        (lookup_pc),
        .lookup_taken     (lookup_taken),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .branch           (branch),
        .funct3           (funct3),
        .a                (a),
        .b                (b),
        .pc               (pc),
        .pred_taken       (pred_taken),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .sel              (sel),
        .mispredict       (mispredict),
        .illegal          (illegal),
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: counter values as plain integers 0..3.
    int m_tbl [DEPTH];
    int m_bc;
    int m_mc;
    bit m_ov;
    bit m_sel;
    bit m_mis;
    bit m_ill;

    task automatic check_output(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int idx_of(logic [63:0] p);
        longint unsigned word;
        word = p >> 2;
        return int'(word % DEPTH);
    endfunction

    function automatic bit ref_taken(logic [2:0] f3, logic [63:0] x, logic [63:0] y,
                                     output bit legal);
        longint          sx = x;
        longint          sy = y;
        longint unsigned ux = x;
        longint unsigned uy = y;
        legal = 1'b1;
        case (f3)
            3'd0:    return ux == uy;
            3'd1:    return ux != uy;
            3'd4:    return sx <  sy;
            3'd5:    return sx >= sy;
            3'd6:    return ux <  uy;
            3'd7:    return ux >= uy;
            default: begin legal = 1'b0; return 1'b0; end
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_tbl[i] = 1;
        m_bc = 0; m_mc = 0;
        m_ov = 0; m_sel = 0; m_mis = 0; m_ill = 0;
    endtask

    // One clock cycle: drive, check combinational outputs, advance model, check registers.
    task automatic apply_stimulus(bit iv, bit br, logic [2:0] f3, logic [63:0] av,
                                  logic [63:0] bv, logic [63:0] pcv, bit pt, bit ordy,
                                  logic [63:0] lpc);
        bit acc, t, lg, s;
        int i;
        in_valid = iv; branch = br; funct3 = f3; a = av; b = bv; pc = pcv;
        pred_taken = pt; out_ready = ordy; lookup_pc = lpc;
        #2;
        check_output("in_ready", 64'(in_ready), 64'(!m_ov || ordy));
        check_output("lookup_taken", 64'(lookup_taken), 64'(m_tbl[idx_of(lpc)] >= 2));
        acc = iv && (!m_ov || ordy);
        if (acc) begin
            t = ref_taken(f3, av, bv, lg);
            s = br && lg && t;
            m_sel = s;
            m_ill = br && !lg;
            m_mis = s ^ pt;
            m_ov  = 1'b1;
            if (br && lg) begin
                m_bc++;
                if (m_mis) m_mc++;
                i = idx_of(pcv);
                if (s) m_tbl[i] = (m_tbl[i] == 3) ? 3 : m_tbl[i] + 1;
                else   m_tbl[i] = (m_tbl[i] == 0) ? 0 : m_tbl[i] - 1;
            end
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        @(posedge clk);
        #1;
        check_output("out_valid", 64'(out_valid), 64'(m_ov));
        if (m_ov) begin
            check_output("sel", 64'(sel), 64'(m_sel));
            check_output("mispredict", 64'(mispredict), 64'(m_mis));
            check_output("illegal", 64'(illegal), 64'(m_ill));
        end
        check_output("branch_count", 64'(branch_count), 64'(m_bc));
        check_output("mispredict_count", 64'(mispredict_count), 64'(m_mc));
    endtask

    function automatic logic [63:0] pick_op();
        case ($urandom_range(0, 4))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return '1;
            3:       return 64'h8000_0000_0000_0000;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        logic [63:0] rpc;
        reset = 1'b1;
        in_valid = 0; branch = 0; funct3 = 0; a = 0; b = 0; pc = 0;
        pred_taken = 0; out_ready = 1; lookup_pc = 64'h40;
        model_reset();
        #12;
        check_output("rst_out_valid", 64'(out_valid), 64'd0);
        check_output("rst_sel", 64'(sel), 64'd0);
        check_output("rst_mispredict", 64'(mispredict), 64'd0);
        check_output("rst_illegal", 64'(illegal), 64'd0);
        check_output("rst_branch_count", 64'(branch_count), 64'd0);
        check_output("rst_mispredict_count", 64'(mispredict_count), 64'd0);
        check_output("rst_lookup", 64'(lookup_taken), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("in_ready_after_reset", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Signed versus unsigned comparisons on -1 and 1.
        apply_stimulus(1, 1, 3'b101, '1, 64'd1, 64'h8, 0, 1, 64'h8);
        apply_stimulus(1, 1, 3'b111, '1, 64'd1, 64'h8, 0, 1, 64'h8);
        apply_stimulus(1, 1, 3'b100, '1, 64'd1, 64'h8, 1, 1, 64'h8);
        apply_stimulus(0, 0, 3'b000, 0, 0, 0, 0, 1, 64'h8);

        // Train pc 0x40 with three taken beq, then one not-taken to show saturation.
        for (int k = 0; k < 3; k++)
            apply_stimulus(1, 1, 3'b000, 64'd7, 64'd7, 64'h40, 0, 1, 64'h40);
        apply_stimulus(0, 0, 3'b000, 0, 0, 0, 0, 1, 64'h40);
        apply_stimulus(1, 1, 3'b000, 64'd7, 64'd8, 64'h40, 1, 1, 64'h40);
        apply_stimulus(0, 0, 3'b000, 0, 0, 0, 0, 1, 64'h40);

        // Backpressure: stall four cycles, then drain back-to-back.
        apply_stimulus(1, 1, 3'b000, 64'd3, 64'd3, 64'h10, 0, 1, 64'h10);
        for (int k = 0; k < 4; k++)
            apply_stimulus(1, 1, 3'b001, 64'd3, 64'd4, 64'h14, 0, 0, 64'h14);
        for (int k = 0; k < 3; k++)
            apply_stimulus(1, 1, 3'b001, 64'd3, 64'(k), 64'h14, 0, 1, 64'h14);
        apply_stimulus(0, 0, 3'b000, 0, 0, 0, 0, 1, 64'h14);

        // Illegal condition codes and non-branch requests.
        apply_stimulus(1, 1, 3'b010, 64'd1, 64'd1, 64'h40, 1, 1, 64'h40);
        apply_stimulus(1, 1, 3'b011, 64'd1, 64'd1, 64'h40, 0, 1, 64'h40);
        apply_stimulus(1, 0, 3'b000, 64'd1, 64'd1, 64'h40, 1, 1, 64'h40);
        apply_stimulus(0, 0, 3'b000, 0, 0, 0, 0, 1, 64'h40);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            rpc = {$urandom, $urandom};
            apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 9) != 0,
                           3'($urandom_range(0, 7)), pick_op(), pick_op(), rpc,
                           $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0,
                           ($urandom_range(0, 1) == 1) ? rpc : {$urandom, $urandom});
        end

        // Reset with a pending result and a trained entry.
        apply_stimulus(0, 0, 3'b000, 0, 0, 0, 0, 1, 64'h40);
        for (int k = 0; k < 3; k++)
            apply_stimulus(1, 1, 3'b000, 64'd5, 64'd5, 64'h40, 0, 1, 64'h40);
        apply_stimulus(1, 1, 3'b000, 64'd5, 64'd5, 64'h40, 0, 0, 64'h40);
        reset = 1'b1;
        in_valid = 1'b0;
        model_reset();
        #2;
        check_output("midrst_out_valid", 64'(out_valid), 64'd0);
        check_output("midrst_branch_count", 64'(branch_count), 64'd0);
        check_output("midrst_mispredict_count", 64'(mispredict_count), 64'd0);
        check_output("midrst_lookup", 64'(lookup_taken), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_output("midrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        apply_stimulus(0, 0, 3'b000, 0, 0, 0, 0, 1, 64'h40);
        apply_stimulus(1, 1, 3'b000, 64'd5, 64'd5, 64'h40, 0, 1, 64'h40);
        apply_stimulus(0, 0, 3'b000, 0, 0, 0, 0, 1, 64'h40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
